// File: rtl/tone_bank.sv
// Multi-channel square-wave tone generator with live-retunable half-periods,
// global phase resync and a registered popcount of the channel outputs.
module tone_bank #(
    parameter int unsigned CHANNELS = 7,
    parameter int unsigned CNT_W    = 18,
    parameter int unsigned ADDR_W   = 3,
    parameter logic [CHANNELS*CNT_W-1:0] DEFAULT_HALF = {
        18'd143172, 18'd151685, 18'd170264, 18'd191109,
        18'd202478, 18'd227272, 18'd255102
    }
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [CHANNELS-1:0]              enable,
    input  logic                             resync,
    input  logic                             wr_en,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [CNT_W-1:0]                 wr_data,
    output logic [CHANNELS-1:0]              speaker,
    output logic [$clog2(CHANNELS+1)-1:0]    mix
);

    localparam int unsigned MIX_W = $clog2(CHANNELS + 1);

    logic [CNT_W-1:0]    cnt_q  [CHANNELS];
    logic [CNT_W-1:0]    cnt_d  [CHANNELS];
    logic [CNT_W-1:0]    half_q [CHANNELS];
    logic [CNT_W-1:0]    half_d [CHANNELS];
    logic [CHANNELS-1:0] spk_q;
    logic [CHANNELS-1:0] spk_d;
    logic [MIX_W-1:0]    mix_q;
    logic [MIX_W-1:0]    mix_d;

    // Per-channel counters, half-period writes and output popcount.
    always_comb begin
        spk_d = spk_q;
        mix_d = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt_d[i]  = cnt_q[i];
            half_d[i] = half_q[i];
            if (resync || !enable[i]) begin
                cnt_d[i] = '0;
                spk_d[i] = 1'b0;
            end else if (cnt_q[i] >= half_q[i]) begin
                // >= lets a freshly written smaller half-period toggle at once
                cnt_d[i] = '0;
                spk_d[i] = ~spk_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            // Addresses at or beyond CHANNELS never match, so they are dropped.
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
                half_d[i] = wr_data;
            end
            mix_d = mix_d + MIX_W'(spk_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt_q[i]  <= '0;
                half_q[i] <= DEFAULT_HALF[i*CNT_W +: CNT_W];
            end
            spk_q <= '0;
            mix_q <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt_q[i]  <= cnt_d[i];
                half_q[i] <= half_d[i];
            end
            spk_q <= spk_d;
            mix_q <= mix_d;
        end
    end

    assign speaker = spk_q;
    assign mix     = mix_q;

endmodule

// File: doc/tone_bank.md
# tone_bank

Parametrised multi-channel square-wave tone generator for the audio output path. Each channel has a runtime-programmable half-period register, a gate input and a square-wave output. Channels can be phase-aligned with a global resync pulse. A registered count of active-high outputs is provided to drive a summing PWM/DAC stage. Half-periods load from a parameter vector at reset, so the block plays a fixed scale with no writes and can be retuned live.

## Interface
- CHANNELS, default 7: number of tone channels (1..16).
- CNT_W, default 18: width of each counter and half-period register.
- ADDR_W, default 3: width of wr_addr; must satisfy 2^ADDR_W >= CHANNELS.
- DEFAULT_HALF, default {F4=143172, E4=151685, D4=170264, C4=191109, B3=202478, A3=227272, G3=255102}: flat CHANNELS*CNT_W vector; channel i uses bits [i*CNT_W +: CNT_W].
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  CHANNELS  per-channel gate; bit i high runs channel i.
- resync  in  1  one-cycle pulse; clears every channel's counter and output.
- wr_en  in  1  half-period write strobe.
- wr_addr  in  ADDR_W  channel index for the write.
- wr_data  in  CNT_W  new half-period value H.
- speaker  out  CHANNELS  per-channel square wave, registered.
- mix  out  $clog2(CHANNELS+1)  registered popcount of speaker.

## Operation
- Per-channel state: counter cnt[i] (CNT_W bits), half-period half[i] (CNT_W bits), output speaker[i].
- reset: half[i] <= DEFAULT_HALF slice i, cnt[i] <= 0, speaker <= 0, mix <= 0. Reset overrides every other input.
- Per-channel priority below reset is resync, then enable[i] low, then normal count.
- resync high: all cnt <= 0 and all speaker <= 0 in the same cycle, regardless of enable.
- enable[i] low: cnt[i] <= 0 and speaker[i] <= 0, so a channel always restarts from phase 0.
- Normal count, with enable[i] high:
  - If cnt[i] >= half[i]: cnt[i] <= 0 and speaker[i] toggles.
  - Otherwise cnt[i] <= cnt[i] + 1.
  - The >= comparison, rather than ==, makes a live write of a smaller H toggle on the next enabled edge instead of running up to 2^CNT_W.
- Resulting waveform: period = 2*(H+1) clk cycles, 50% duty. H = 0 toggles on every enabled edge (period 2).
- Write port:
  - wr_en high with wr_addr < CHANNELS: half[wr_addr] <= wr_data.
  - wr_addr >= CHANNELS: the write is silently ignored.
  - Writes are accepted during resync and while the channel is disabled. They do not disturb cnt or speaker.
- Same-cycle write and compare on one channel: the compare uses the old half value. The new value applies from the next edge.
- mix <= popcount of the speaker value present before the edge, i.e. mix lags speaker by one cycle. Width is sized so all-high does not overflow.
- Counter arithmetic is unsigned, CNT_W bits. cnt never exceeds max(half) reached before the compare, so it never wraps.

## Timing
- No handshake; all inputs are sampled at the rising edge of clk, and a write takes effect in one cycle.
- Enable rises before edge e0, with cnt = 0:
  - With half = H, the first toggle (speaker 0 -> 1) is registered at edge e0 + H.
  - Subsequent toggles occur every H+1 edges.
- Enable falls before edge e: speaker is 0 and cnt is 0 after edge e.
- resync before edge e: all speaker bits are 0 after e. Channels still enabled produce their first toggle at e + 1 + H.
- mix is valid one cycle after the speaker value it counts.
- Reset asserted mid-tone: after the next edge, outputs are 0 and half registers hold their defaults; earlier writes are lost.

## Test plan
- Reset with defaults, enable = 7'b0000001: speaker[0] first rises 255103 edges after enable, then toggles every 255103 edges; all other bits stay 0; mix alternates 0/1 one cycle behind.
- Write ch2 H = 3, enable[2] high: speaker[2] has period 8 cycles, high for 4; write addr 7 with data 1 leaves every half register unchanged.
- ch1 H = 10 running with cnt = 8, write H = 2: toggle on the next edge (cnt >= 2), then period 6 thereafter.
- All 7 channels with H = 0, enabled together: speaker goes 0x7F, 0x00, 0x7F and so on; mix reads 7, 0, 7 lagging one cycle.
- Channels 0 and 1 at H = 4 and H = 6 running out of phase, pulse resync: both outputs are 0 next cycle; both rise 5 and 7 edges after resync respectively.
- Assert reset while channels toggle, with earlier writes pending: next cycle speaker = 0, mix = 0, half restored to DEFAULT_HALF; a simultaneous wr_en in the reset cycle is ignored.
